// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first adder built from one full-adder cell
// and a carry flop, stepped over WIDTH clocks per operation.
// Optional feature macro: SERIAL_SUB_MODE_EN adds a 'sub' input that turns
// the operation into a - b, computed as a + ~b + 1.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic invert_b;
  logic bit_b;
  logic bit_s;
  logic bit_c;

`ifdef SERIAL_SUB_MODE_EN
  logic sub_q, sub_d;
  assign invert_b = sub_q;
`else
  assign invert_b = 1'b0;
`endif

  // Full-adder cell acting on the current LSBs and the stored carry.
  always_comb begin
    bit_b = b_sh_q[0] ^ invert_b;
    bit_s = a_sh_q[0] ^ bit_b ^ c_q;
    bit_c = (a_sh_q[0] & bit_b) | (a_sh_q[0] & c_q) | (bit_b & c_q);
  end

  // Next-state and datapath control: load on start, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_SUB_MODE_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_MODE_EN
          sub_d   = sub;
          c_d     = sub;
`else
          c_d     = 1'b0;
`endif
        end
      end
      RUN: begin
        s_sh_d = (s_sh_q >> 1) | {bit_s, {(WIDTH-1){1'b0}}};
        c_d    = bit_c;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = s_sh_d;
          cout_d  = bit_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_SUB_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder (WIDTH=4) with a
// cycle-timeline reference model checked every cycle on the falling edge.
module tb_serial_adder;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int total = 0;
  int bad = 0;
  int tickNo = 0;
  int doneCount = 0;
  int busyCycles = 0;

  // Reference model: cycles since the accepted start (-1 when idle)
  int               since = -1;
  logic [WIDTH:0]   pending = '0;
  logic [WIDTH-1:0] expSum = '0;
  logic             expCout = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
`ifdef SERIAL_SUB_MODE_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at tick %0d: got %0d expected %0d", name, tickNo, act, exp);
    end
  endtask

  // Model step at the rising edge: decides what the result is and when it appears.
  task automatic modelStep();
    logic subEff;
    subEff = 1'b0;
`ifdef SERIAL_SUB_MODE_EN
    subEff = sub;
`endif
    if (rst) begin
      since   = -1;
      expSum  = '0;
      expCout = 1'b0;
    end else if (since < 0) begin
      if (start) begin
        since = 0;
        if (subEff)
          pending = (WIDTH+1)'({1'b0, a}) + (WIDTH+1)'({1'b0, ~b}) + (WIDTH+1)'(1);
        else
          pending = (WIDTH+1)'({1'b0, a}) + (WIDTH+1)'({1'b0, b});
      end
    end else begin
      since++;
      if (since == WIDTH) begin
        expSum  = pending[WIDTH-1:0];
        expCout = pending[WIDTH];
      end else if (since == WIDTH + 1) begin
        since = -1;
      end
    end
  endtask

  // One clock: model at the rising edge, compare DUT against model at the falling edge.
  task automatic tick();
    logic expBusy;
    logic expDone;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    tickNo++;
    expBusy = (since >= 0) && (since < WIDTH);
    expDone = (since == WIDTH);
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("done", 32'(done), 32'(expDone));
    checkOutput("sum",  32'(sum),  32'(expSum));
    checkOutput("cout", 32'(cout), 32'(expCout));
    if (done === 1'b1) doneCount++;
    if (busy === 1'b1) busyCycles++;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    a = av;
    b = bv;
`ifdef SERIAL_SUB_MODE_EN
    sub = sv;
`else
    if (sv) $display("[TB] note: sub requested without subtract support");
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
  endtask

  // Wait (bounded) for done, pin the result to hand-computed literals, then let the DUT return to IDLE.
  task automatic waitDone(input string name, input logic [WIDTH-1:0] wantSum, input logic wantCout,
                          input int wantLat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: got no done expected done within 20 cycles", name);
    end else begin
      checkOutput({name, " sum"}, 32'(sum), 32'(wantSum));
      checkOutput({name, " cout"}, 32'(cout), 32'(wantCout));
      if (wantLat >= 0) checkOutput({name, " latency"}, 32'(n), 32'(wantLat));
    end
    tick();
  endtask

  initial begin
    int d0;
    int prev;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_SUB_MODE_EN
    sub = 1'b0;
`endif

    // 1. reset, then idle with no start
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("t1 idle busy", 32'(busy), 32'd0);
    checkOutput("t1 idle sum", 32'(sum), 32'd0);
    checkOutput("t1 no done", 32'(doneCount), 32'd0);

    // 2. basic add and carry-out
    busyCycles = 0;
    applyStimulus(4'd5, 4'd3, 1'b0);
    waitDone("t2 5+3", 4'd8, 1'b0, WIDTH);
    checkOutput("t2 busy cycles", 32'(busyCycles), 32'(WIDTH));
    applyStimulus(4'd15, 4'd1, 1'b0);
    waitDone("t2 15+1", 4'd0, 1'b1, WIDTH);

`ifdef SERIAL_SUB_MODE_EN
    // 3. subtract mode
    applyStimulus(4'd3, 4'd5, 1'b1);
    waitDone("t3 3-5", 4'd14, 1'b0, WIDTH);
    applyStimulus(4'd9, 4'd4, 1'b1);
    waitDone("t3 9-4", 4'd5, 1'b1, WIDTH);
    applyStimulus(4'd6, 4'd2, 1'b0);
    waitDone("t3 6+2 sub=0", 4'd8, 1'b0, WIDTH);
`endif

    // 4. start during RUN is ignored
    d0 = doneCount;
    applyStimulus(4'd7, 4'd7, 1'b0);
    tick();
    applyStimulus(4'd1, 4'd1, 1'b0);
    waitDone("t4 7+7", 4'd14, 1'b0, WIDTH - 2);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t4 one done", 32'(doneCount - d0), 32'd1);

    // 5. reset on the second RUN cycle aborts the operation
    d0 = doneCount;
    applyStimulus(4'd6, 4'd6, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5 abort busy", 32'(busy), 32'd0);
    checkOutput("t5 abort sum", 32'(sum), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t5 no done", 32'(doneCount - d0), 32'd0);
    applyStimulus(4'd2, 4'd2, 1'b0);
    waitDone("t5 2+2", 4'd4, 1'b0, WIDTH);

    // 6. start held high: back-to-back operations
    d0 = doneCount;
    prev = 0;
    a = 4'd1;
    b = 4'd2;
`ifdef SERIAL_SUB_MODE_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done === 1'b1) begin
        checkOutput("t6 sum", 32'(sum), 32'd3);
        if (prev > 0) checkOutput("t6 spacing", 32'(tickNo - prev), 32'd6);
        prev = tickNo;
      end
    end
    start = 1'b0;
    checkOutput("t6 done count", 32'(doneCount - d0), 32'd4);
    for (int i = 0; i < 8; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
